// File: rtl/perf_counter_pkg.sv
// Shared constants for the performance counter array: register map offsets,
// section stride and the status-block base helper.
package perf_counter_pkg;

    // Each section occupies SEC_STRIDE consecutive word addresses
    localparam int SEC_STRIDE = 4;

    localparam logic [1:0] OFS_TIME_LO = 2'd0;
    localparam logic [1:0] OFS_TIME_HI = 2'd1;
    localparam logic [1:0] OFS_EVT_LO  = 2'd2;
    localparam logic [1:0] OFS_EVT_HI  = 2'd3;

    localparam int STAT_TOVF = 0;
    localparam int STAT_EOVF = 1;

    // First word address of the status block
    function automatic int stat_base(input int num_sections);
        return num_sections * SEC_STRIDE;
    endfunction

endpackage

// File: rtl/perf_counter_section.sv
// One timed section: enable flop, cycle and event counters, hi-word
// shadows for atomic readback and sticky overflow flags.
// Ports: clk, reset (sync, active-high), go/stop strobes, gen (global enable),
//   grst (global clear), rd_lo_time/rd_lo_evt (latch hi shadows),
//   clr_tovf/clr_eovf (W1C), event_in (only with PERF_CNT_EXT_EVENT_EN),
//   en, time_cnt, evt_cnt, time_shadow, evt_shadow, tovf, eovf.
module perf_counter_section
    import perf_counter_pkg::*;
#(
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic             stop,
    input  logic             gen,
    input  logic             grst,
    input  logic             rd_lo_time,
    input  logic             rd_lo_evt,
    input  logic             clr_tovf,
    input  logic             clr_eovf,
`ifdef PERF_CNT_EXT_EVENT_EN
    input  logic             event_in,
`endif
    output logic             en,
    output logic [CNT_W-1:0] time_cnt,
    output logic [CNT_W-1:0] evt_cnt,
    output logic [CNT_W-33:0] time_shadow,
    output logic [CNT_W-33:0] evt_shadow,
    output logic             tovf,
    output logic             eovf
);

    logic             time_inc;
    logic             evt_inc;
    logic             time_wrap;
    logic             evt_wrap;
    logic [CNT_W-1:0] time_nxt;
    logic [CNT_W-1:0] evt_nxt;

    assign time_inc = en & gen;
`ifdef PERF_CNT_EXT_EVENT_EN
    assign evt_inc  = event_in & en & gen;
`else
    assign evt_inc  = go & gen;
`endif

    assign time_wrap = time_inc & (&time_cnt);
    assign evt_wrap  = evt_inc & (&evt_cnt);
    assign time_nxt  = time_cnt + CNT_W'(time_inc);
    assign evt_nxt   = evt_cnt + CNT_W'(evt_inc);

    always_ff @(posedge clk) begin
        if (reset || grst) begin
            en          <= 1'b0;
            time_cnt    <= '0;
            evt_cnt     <= '0;
            time_shadow <= '0;
            evt_shadow  <= '0;
            tovf        <= 1'b0;
            eovf        <= 1'b0;
        end else begin
            if (go) begin
                en <= 1'b1;
            end else if (stop) begin
                en <= 1'b0;
            end
            time_cnt <= time_nxt;
            evt_cnt  <= evt_nxt;
            // Hi word is frozen at the moment the lo word is sampled
            if (rd_lo_time) begin
                time_shadow <= time_cnt[CNT_W-1:32];
            end
            if (rd_lo_evt) begin
                evt_shadow <= evt_cnt[CNT_W-1:32];
            end
            // A wrap in the same cycle as a clear keeps the flag set
            tovf <= time_wrap | (tovf & ~clr_tovf);
            eovf <= evt_wrap | (eovf & ~clr_eovf);
        end
    end

endmodule

// File: rtl/perf_counter_array.sv
// Bus-mapped array of timed sections: address decode, global enable/reset,
// status block and registered read mux. Optional macro PERF_CNT_EXT_EVENT_EN
// adds event_in. Ports: clk, reset, address, begintransfer, read, write,
// writedata, event_in (macro only), readdata.
module perf_counter_array
    import perf_counter_pkg::*;
#(
    parameter int  NUM_SECTIONS = 8,
    parameter int  CNT_W        = 64,
    localparam int ADDR_W       = $clog2(NUM_SECTIONS * SEC_STRIDE) + 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ADDR_W-1:0]       address,
    input  logic                    begintransfer,
    input  logic                    read,
    input  logic                    write,
    input  logic [31:0]             writedata,
`ifdef PERF_CNT_EXT_EVENT_EN
    input  logic [NUM_SECTIONS-1:0] event_in,
`endif
    output logic [31:0]             readdata
);

    localparam int SEC_IW = ADDR_W - 2;
    localparam int HI_W   = CNT_W - 32;
    localparam int BASE   = stat_base(NUM_SECTIONS);

    localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE);
    localparam logic [ADDR_W-1:0] ST_T   = ADDR_W'(BASE + STAT_TOVF);
    localparam logic [ADDR_W-1:0] ST_E   = ADDR_W'(BASE + STAT_EOVF);

    logic              wr_stb;
    logic              rd_stb;
    logic              in_sec;
    logic [SEC_IW-1:0] sec_idx;
    logic [1:0]        ofs;
    logic              gen;
    logic              grst;
    logic              clr_t_wr;
    logic              clr_e_wr;
    logic [31:0]       rd_mux;
    logic              unused_bits;

    logic [NUM_SECTIONS-1:0] en_v;
    logic [NUM_SECTIONS-1:0] go_v;
    logic [NUM_SECTIONS-1:0] stop_v;
    logic [NUM_SECTIONS-1:0] rdlt_v;
    logic [NUM_SECTIONS-1:0] rdle_v;
    logic [NUM_SECTIONS-1:0] tovf_v;
    logic [NUM_SECTIONS-1:0] eovf_v;

    logic [CNT_W-1:0] time_a [NUM_SECTIONS];
    logic [CNT_W-1:0] evt_a  [NUM_SECTIONS];
    logic [HI_W-1:0]  tsh_a  [NUM_SECTIONS];
    logic [HI_W-1:0]  esh_a  [NUM_SECTIONS];

    assign wr_stb   = write & begintransfer;
    assign rd_stb   = read & begintransfer;
    assign in_sec   = address < BASE_A;
    assign sec_idx  = address[ADDR_W-1:2];
    assign ofs      = address[1:0];
    assign clr_t_wr = wr_stb & (address == ST_T);
    assign clr_e_wr = wr_stb & (address == ST_E);

    // Section 0 is the master bracket for every other section
    assign gen  = en_v[0] | go_v[0];
    assign grst = stop_v[0] & writedata[0];

    assign unused_bits = ^{writedata[31:NUM_SECTIONS], en_v};

    for (genvar s = 0; s < NUM_SECTIONS; s++) begin : g_sec
        logic hit;

        assign hit = in_sec & (sec_idx == SEC_IW'(s));
        assign stop_v[s] = wr_stb & hit & (ofs == OFS_TIME_LO);
        assign go_v[s]   = wr_stb & hit & (ofs == OFS_TIME_HI);
        assign rdlt_v[s] = rd_stb & hit & (ofs == OFS_TIME_LO);
        assign rdle_v[s] = rd_stb & hit & (ofs == OFS_EVT_LO);

        perf_counter_section #(
            .CNT_W(CNT_W)
        ) u_sec (
            .clk        (clk),
            .reset      (reset),
            .go         (go_v[s]),
            .stop       (stop_v[s]),
            .gen        (gen),
            .grst       (grst),
            .rd_lo_time (rdlt_v[s]),
            .rd_lo_evt  (rdle_v[s]),
            .clr_tovf   (clr_t_wr & writedata[s]),
            .clr_eovf   (clr_e_wr & writedata[s]),
`ifdef PERF_CNT_EXT_EVENT_EN
            .event_in   (event_in[s]),
`endif
            .en         (en_v[s]),
            .time_cnt   (time_a[s]),
            .evt_cnt    (evt_a[s]),
            .time_shadow(tsh_a[s]),
            .evt_shadow (esh_a[s]),
            .tovf       (tovf_v[s]),
            .eovf       (eovf_v[s])
        );
    end

    always_comb begin
        rd_mux = '0;
        for (int s = 0; s < NUM_SECTIONS; s++) begin
            if (in_sec && (sec_idx == SEC_IW'(s))) begin
                unique case (ofs)
                    OFS_TIME_LO: rd_mux = time_a[s][31:0];
                    OFS_TIME_HI: rd_mux = 32'(tsh_a[s]);
                    OFS_EVT_LO:  rd_mux = evt_a[s][31:0];
                    OFS_EVT_HI:  rd_mux = 32'(esh_a[s]);
                endcase
            end
        end
        unique case (1'b1)
            (address == ST_T): rd_mux = 32'(tovf_v);
            (address == ST_E): rd_mux = 32'(eovf_v);
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            readdata <= '0;
        end else begin
            readdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_perf_counter_array.sv
// Scoreboard bench for perf_counter_array (CNT_W=34 so wrap is reachable).
// Reads push expected words; a monitor pops them one cycle after each read.
module tb_perf_counter_array;

    localparam int NS = 8;
    localparam int CW = 34;
    localparam int AW = $clog2(NS * 4) + 1;
`ifdef PERF_CNT_EXT_EVENT_EN
    localparam logic [31:0] GOEV = 32'd0;
`else
    localparam logic [31:0] GOEV = 32'd1;
`endif

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] address;
    logic          begintransfer;
    logic          read;
    logic          write;
    logic [31:0]   writedata;
    logic [31:0]   readdata;
`ifdef PERF_CNT_EXT_EVENT_EN
    logic [NS-1:0] event_in;
`endif

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    logic rd_d = 1'b0;

    always #5 clk = ~clk;

    perf_counter_array #(
        .NUM_SECTIONS(NS),
        .CNT_W       (CW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .address      (address),
        .begintransfer(begintransfer),
        .read         (read),
        .write        (write),
        .writedata    (writedata),
`ifdef PERF_CNT_EXT_EVENT_EN
        .event_in     (event_in),
`endif
        .readdata     (readdata)
    );

    always @(posedge clk) rd_d <= read & begintransfer;

    always @(negedge clk) begin
        exp_t e;
        if (rd_d) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_read got %h want none", readdata);
            end else begin
                e = sb.pop_front();
                if (readdata !== e.val) begin
                    miscompares++;
                    $display("FAIL %s got %h want %h", e.name, readdata, e.val);
                end
            end
        end
    end

    task automatic wr(input int a, input logic [31:0] d);
        address = AW'(a);
        writedata = d;
        write = 1'b1;
        begintransfer = 1'b1;
        @(negedge clk);
        write = 1'b0;
        begintransfer = 1'b0;
    endtask

    task automatic rd(input int a, input logic [31:0] v, input string n);
        exp_t e;
        e.name = n;
        e.val = v;
        sb.push_back(e);
        address = AW'(a);
        read = 1'b1;
        begintransfer = 1'b1;
        @(negedge clk);
        read = 1'b0;
        begintransfer = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        read = 1'b0;
        write = 1'b0;
        begintransfer = 1'b0;
        address = '0;
        writedata = '0;
`ifdef PERF_CNT_EXT_EVENT_EN
        event_in = '0;
`endif
        idle(3);
        reset = 1'b0;

        // Reset state of every mapped word plus unmapped space
        for (int a = 0; a < NS * 4 + 2; a++) begin
            rd(a, 32'd0, $sformatf("reset_w%0d", a));
        end
        rd(34, 32'd0, "unmapped_34");
        rd(63, 32'd0, "unmapped_63");

        // Section 0 bracket of 10 idle cycles
        wr(1, 0);
        idle(10);
        wr(0, 0);
        rd(0, 32'd11, "t2_time0_lo");
        rd(2, GOEV, "t2_evt0_lo");
        rd(1, 32'd0, "t2_time0_hi");
        rd(3, 32'd0, "t2_evt0_hi");

        // Global enable gating of section 3
        wr(13, 0);
        idle(5);
        rd(12, 32'd0, "t3_gated_time3");
        rd(14, 32'd0, "t3_gated_evt3");
        wr(1, 0);
        rd(12, 32'd1, "t3_time3_a");
        rd(12, 32'd2, "t3_time3_b");
        wr(0, 0);
        rd(12, 32'd4, "t3_time3_frozen");
        rd(0, 32'd14, "t3_time0");
        wr(12, 0);

        // Atomic hi/lo read across a lo-word carry
        force dut.g_sec[0].u_sec.time_cnt = 34'h1_FFFF_FFFE;
        idle(1);
        release dut.g_sec[0].u_sec.time_cnt;
        wr(1, 0);
        rd(0, 32'hFFFF_FFFE, "t5_lo");
        idle(4);
        rd(1, 32'd1, "t5_hi_shadow");
        rd(0, 32'd4, "t5_lo2");
        rd(1, 32'd2, "t5_hi_new");
        wr(0, 0);

        // Wrap of section 1, W1C clear, then clear colliding with a wrap
        force dut.g_sec[1].u_sec.time_cnt = 34'h3_FFFF_FFFE;
        idle(1);
        release dut.g_sec[1].u_sec.time_cnt;
        wr(5, 0);
        wr(1, 0);
        idle(1);
        wr(0, 0);
        rd(4, 32'd1, "t4_wrap_lo");
        rd(5, 32'd0, "t4_wrap_hi");
        rd(32, 32'h2, "t4_tovf_set");
        rd(33, 32'h0, "t4_eovf");
        wr(32, 32'h2);
        rd(32, 32'h0, "t4_tovf_clr");
        force dut.g_sec[1].u_sec.time_cnt = 34'h3_FFFF_FFFE;
        idle(1);
        release dut.g_sec[1].u_sec.time_cnt;
        wr(1, 0);
        wr(32, 32'h2);
        wr(0, 0);
        rd(32, 32'h2, "t4_set_wins");
        rd(4, 32'd1, "t4_wrap2_lo");
        wr(4, 0);

        // Global reset while several sections run
        wr(1, 0);
        wr(9, 0);
        wr(29, 0);
        idle(3);
        wr(0, 1);
        rd(1, 32'd0, "t6_shadow0");
        rd(0, 32'd0, "t6_time0");
        rd(8, 32'd0, "t6_time2");
        rd(28, 32'd0, "t6_time7");
        rd(2, 32'd0, "t6_evt0");
        rd(4, 32'd0, "t6_time1");
        rd(32, 32'd0, "t6_tovf");
        wr(1, 0);
        idle(2);
        rd(8, 32'd0, "t6_en2_cleared");
        rd(0, 32'd3, "t6_time0_run");
        wr(0, 0);

`ifdef PERF_CNT_EXT_EVENT_EN
        wr(1, 0);
        wr(9, 0);
        for (int i = 0; i < 7; i++) begin
            event_in[2] = 1'b1;
            idle(1);
            event_in[2] = 1'b0;
            idle(1);
        end
        wr(0, 0);
        rd(10, 32'd7, "ext_evt2");
        rd(2, 32'd0, "ext_evt0");
`endif

        idle(3);
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL sb_drain got %0d want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
